// File: rtl/bus_timer_pkg.sv
// Shared constants and types for the bus_timer machine timer.
// Register selects are word indices taken from address bits [4:2].
package bus_timer_pkg;

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_CTRL        = 3'd4;
  localparam logic [2:0] REG_PRESCALE    = 3'd5;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_PENDING = 2;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/bus_timer_if.sv
// Request/ready bus between the CPU address decoder (master) and the timer (slave).
interface bus_timer_if;

  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (
    output i_request, i_rw, i_address, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata,
    output o_rdata, o_ready
  );

endinterface

// File: rtl/bus_timer_prescaler.sv
// Divides the clock by period_i (0 treated as 1) and emits a one-cycle tick.
module bus_timer_prescaler (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  input  logic        clear_i,
  output logic        tick_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] lastCount;

  // ">=" keeps the counter from running away if the period ever shrinks below it.
  always_comb begin
    lastCount = (period_i == 32'd0) ? 32'd0 : period_i - 32'd1;
    tick_o    = enable_i && !clear_i && (count_q >= lastCount);
    count_d   = count_q;
    if (clear_i || tick_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) on the request/ready bus.
// Optional macro TIMER_SNAPSHOT_EN: a MTIME_LO read latches mtime[63:32] for the next MTIME_HI read.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 50
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  bus_timer_if.slave  bus,
  output logic        o_interrupt
);

  bus_state_e  state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        ctrlEnable_q, ctrlEnable_d;
  logic        irqEn_q, irqEn_d;
  logic [31:0] prescale_q, prescale_d;
  logic        irq_q, irq_d;

  logic        access, wrEn, rdEn, tick, pending, prescaleClear;
  logic [2:0]  regSel;
  logic [31:0] readValue;
  logic [31:0] mtimeHiRead;
  logic        unused_addr;

  assign unused_addr = ^{bus.i_address[31:5], bus.i_address[1:0]};

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b0;
        if (bus.i_request) begin
          access  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!bus.i_request) begin
          ready_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wrEn          = access && bus.i_rw;
  assign rdEn          = access && !bus.i_rw;
  assign regSel        = bus.i_address[4:2];
  assign pending       = (mtime_q >= mtimecmp_q);
  assign prescaleClear = wrEn && (regSel == REG_PRESCALE);

  bus_timer_prescaler u_prescaler (
    .clock_i  (i_clock),
    .reset_ni (i_reset_n),
    .enable_i (ctrlEnable_q),
    .period_i (prescale_q),
    .clear_i  (prescaleClear),
    .tick_o   (tick)
  );

`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (rdEn && (regSel == REG_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign mtimeHiRead = shadow_q;
`else
  assign mtimeHiRead = mtime_q[63:32];
`endif

  always_comb begin
    readValue = '0;
    case (regSel)
      REG_MTIME_LO:    readValue = mtime_q[31:0];
      REG_MTIME_HI:    readValue = mtimeHiRead;
      REG_MTIMECMP_LO: readValue = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: readValue = mtimecmp_q[63:32];
      REG_CTRL: begin
        readValue[CTRL_ENABLE]  = ctrlEnable_q;
        readValue[CTRL_IRQ_EN]  = irqEn_q;
        readValue[CTRL_PENDING] = pending;
      end
      REG_PRESCALE:    readValue = prescale_q;
      default:         readValue = '0;
    endcase
  end

  // A bus write to either mtime half overrides (and swallows) a coincident tick.
  always_comb begin
    rdata_d      = rdEn ? readValue : rdata_q;
    mtime_d      = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d   = mtimecmp_q;
    ctrlEnable_d = ctrlEnable_q;
    irqEn_d      = irqEn_q;
    prescale_d   = prescale_q;
    irq_d        = irqEn_q && pending;
    if (wrEn) begin
      case (regSel)
        REG_MTIME_LO:    mtime_d = {mtime_q[63:32], bus.i_wdata};
        REG_MTIME_HI:    mtime_d = {bus.i_wdata, mtime_q[31:0]};
        REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.i_wdata};
        REG_MTIMECMP_HI: mtimecmp_d = {bus.i_wdata, mtimecmp_q[31:0]};
        REG_CTRL: begin
          ctrlEnable_d = bus.i_wdata[CTRL_ENABLE];
          irqEn_d      = bus.i_wdata[CTRL_IRQ_EN];
        end
        REG_PRESCALE:    prescale_d = bus.i_wdata;
        default:         ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= MTIMECMP_RESET;
      ctrlEnable_q <= 1'b0;
      irqEn_q      <= 1'b0;
      prescale_q   <= 32'(PRESCALE);
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      ctrlEnable_q <= ctrlEnable_d;
      irqEn_q      <= irqEn_d;
      prescale_q   <= prescale_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.o_rdata = rdata_q;
  assign bus.o_ready = ready_q;
  assign o_interrupt = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: reset table, prescaler, interrupt, carry/wrap,
// handshake hold and reset corner cases, and MTIME_HI snapshot behaviour.
module tb_bus_timer;

  localparam logic [31:0] A_MTIME_LO    = 32'h00;
  localparam logic [31:0] A_MTIME_HI    = 32'h04;
  localparam logic [31:0] A_MTIMECMP_LO = 32'h08;
  localparam logic [31:0] A_MTIMECMP_HI = 32'h0C;
  localparam logic [31:0] A_CTRL        = 32'h10;
  localparam logic [31:0] A_PRESCALE    = 32'h14;
  localparam logic [31:0] A_RSVD0       = 32'h18;
  localparam logic [31:0] A_RSVD1       = 32'h1C;

`ifdef TIMER_SNAPSHOT_EN
  localparam logic [31:0] SNAP_HI_EXPECTED = 32'd0;
`else
  localparam logic [31:0] SNAP_HI_EXPECTED = 32'd1;
`endif

  logic clk = 1'b0;
  logic rstN;
  logic irq;

  always #5 clk = ~clk;

  bus_timer_if bus ();

  bus_timer #(.PRESCALE(50)) dut (
    .i_clock     (clk),
    .i_reset_n   (rstN),
    .bus         (bus.slave),
    .o_interrupt (irq)
  );

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    string       name;
    logic [31:0] value;
  } sb_t;
  sb_t sbQueue[$];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] expected;
  } vec_t;
  vec_t resetVec[8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One complete bus access; called and returns on a falling edge.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata);
    int lat;
    bus.i_request = 1'b1;
    bus.i_rw      = rw;
    bus.i_address = addr;
    bus.i_wdata   = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_ready && lat < 8);
    checkOutput("readyRise", 64'(lat), 64'd1);
    rdata = bus.o_rdata;
    bus.i_request = 1'b0;
    @(negedge clk);
    checkOutput("readyFall", 64'(bus.o_ready), 64'd0);
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] unusedRd;
    applyStimulus(1'b1, addr, data, unusedRd);
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] rd;
    sb_t e;
    sbQueue.push_back('{name, expected});
    applyStimulus(1'b0, addr, 32'd0, rd);
    e = sbQueue.pop_front();
    checkOutput(e.name, 64'(rd), 64'(e.value));
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] value);
    applyStimulus(1'b0, addr, 32'd0, value);
  endtask

  task automatic runResetTable();
    for (int i = 0; i < 8; i++) begin
      readCheck(resetVec[i].name, resetVec[i].addr, resetVec[i].expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v, v2;
    int waits, readyHigh, lat;

    resetVec[0] = '{"rstMtimeLo",    A_MTIME_LO,    32'h0000_0000};
    resetVec[1] = '{"rstMtimeHi",    A_MTIME_HI,    32'h0000_0000};
    resetVec[2] = '{"rstMtimecmpLo", A_MTIMECMP_LO, 32'hFFFF_FFFF};
    resetVec[3] = '{"rstMtimecmpHi", A_MTIMECMP_HI, 32'hFFFF_FFFF};
    resetVec[4] = '{"rstCtrl",       A_CTRL,        32'h0000_0000};
    resetVec[5] = '{"rstPrescale",   A_PRESCALE,    32'd50};
    resetVec[6] = '{"rstRsvd0",      A_RSVD0,       32'h0000_0000};
    resetVec[7] = '{"rstRsvd1",      A_RSVD1,       32'h0000_0000};

    bus.i_request = 1'b0;
    bus.i_rw      = 1'b0;
    bus.i_address = '0;
    bus.i_wdata   = '0;
    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("rstReady", 64'(bus.o_ready), 64'd0);
    checkOutput("rstRdata", 64'(bus.o_rdata), 64'd0);
    checkOutput("rstIrq", 64'(irq), 64'd0);

    runResetTable();
    readCheck("aliasPrescale", 32'h0000_0117, 32'd50);
    writeReg(A_RSVD0, 32'hDEAD_BEEF);
    readCheck("rsvdWriteIgnored", A_RSVD0, 32'd0);

    // Prescale of 4: ~10 ticks in 40 cycles.
    writeReg(A_PRESCALE, 32'd4);
    writeReg(A_CTRL, 32'd1);
    repeat (40) @(negedge clk);
    readReg(A_MTIME_LO, v);
    checkOutput("prescale4Count", 64'(v >= 32'd9 && v <= 32'd11), 64'd1);

    writeReg(A_PRESCALE, 32'd0);
    readReg(A_MTIME_LO, v);
    readReg(A_MTIME_LO, v2);
    checkOutput("prescale0EveryCycle", 64'(v2 - v), 64'd2);

    // Interrupt once mtime reaches 20, one cycle registered latency.
    writeReg(A_CTRL, 32'd0);
    writeReg(A_MTIME_LO, 32'd0);
    writeReg(A_MTIME_HI, 32'd0);
    writeReg(A_MTIMECMP_HI, 32'd0);
    writeReg(A_MTIMECMP_LO, 32'd20);
    writeReg(A_PRESCALE, 32'd1);
    writeReg(A_CTRL, 32'd3);
    checkOutput("irqNotEarly", 64'(irq), 64'd0);
    waits = 0;
    while (!irq && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("irqLatency", 64'(waits), 64'd20);
    readCheck("ctrlPendingSet", A_CTRL, 32'h7);
    writeReg(A_MTIMECMP_LO, 32'd1000);
    checkOutput("irqClearByCmp", 64'(irq), 64'd0);
    readCheck("ctrlPendingClear", A_CTRL, 32'h3);
    writeReg(A_MTIMECMP_LO, 32'd5);
    checkOutput("irqReassert", 64'(irq), 64'd1);
    writeReg(A_CTRL, 32'd1);
    checkOutput("irqClearByIrqEn", 64'(irq), 64'd0);
    readCheck("ctrlPendingNoIrqEn", A_CTRL, 32'h5);

    // Bus write to MTIME_LO wins over a same-cycle tick.
    writeReg(A_CTRL, 32'd0);
    writeReg(A_MTIME_HI, 32'd0);
    writeReg(A_PRESCALE, 32'd0);
    writeReg(A_CTRL, 32'd1);
    writeReg(A_MTIME_LO, 32'd100);
    writeReg(A_CTRL, 32'd0);
    readCheck("writeBeatsTickLo", A_MTIME_LO, 32'd102);
    readCheck("writeBeatsTickHi", A_MTIME_HI, 32'd0);

    // Single tick carries into the upper half.
    writeReg(A_PRESCALE, 32'd2);
    writeReg(A_MTIME_LO, 32'hFFFF_FFFF);
    writeReg(A_MTIME_HI, 32'd0);
    writeReg(A_CTRL, 32'd1);
    writeReg(A_CTRL, 32'd0);
    readCheck("carryLo", A_MTIME_LO, 32'd0);
    readCheck("carryHi", A_MTIME_HI, 32'd1);
    writeReg(A_MTIMECMP_LO, 32'h1234);
    checkOutput("rdataHoldOnWrite", 64'(bus.o_rdata), 64'd1);

    writeReg(A_MTIME_LO, 32'hFFFF_FFFF);
    writeReg(A_MTIME_HI, 32'hFFFF_FFFF);
    writeReg(A_CTRL, 32'd1);
    writeReg(A_CTRL, 32'd0);
    readCheck("wrapLo", A_MTIME_LO, 32'd0);
    readCheck("wrapHi", A_MTIME_HI, 32'd0);

    // Request held for many cycles executes once; mid-ACK changes ignored.
    bus.i_request = 1'b1;
    bus.i_rw      = 1'b1;
    bus.i_address = A_MTIME_LO;
    bus.i_wdata   = 32'd5;
    readyHigh = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_ready) readyHigh++;
      if (i == 2) begin
        bus.i_address = A_MTIME_HI;
        bus.i_wdata   = 32'd9;
      end
    end
    checkOutput("holdReadyCycles", 64'(readyHigh), 64'd10);
    bus.i_request = 1'b0;
    @(negedge clk);
    checkOutput("holdReadyFall", 64'(bus.o_ready), 64'd0);
    readCheck("holdSingleWriteLo", A_MTIME_LO, 32'd5);
    readCheck("holdSingleWriteHi", A_MTIME_HI, 32'd0);

    // Reset pulse while in ACK.
    writeReg(A_CTRL, 32'd2);
    bus.i_request = 1'b1;
    bus.i_rw      = 1'b1;
    bus.i_address = A_MTIMECMP_HI;
    bus.i_wdata   = 32'd7;
    @(negedge clk);
    checkOutput("ackBeforeReset", 64'(bus.o_ready), 64'd1);
    rstN = 1'b0;
    bus.i_request = 1'b0;
    @(negedge clk);
    checkOutput("ackResetReady", 64'(bus.o_ready), 64'd0);
    checkOutput("ackResetRdata", 64'(bus.o_rdata), 64'd0);
    rstN = 1'b1;
    runResetTable();

    // Request held through reset re-executes after release.
    rstN = 1'b0;
    bus.i_request = 1'b1;
    bus.i_rw      = 1'b1;
    bus.i_address = A_PRESCALE;
    bus.i_wdata   = 32'd33;
    @(negedge clk);
    checkOutput("reexecInReset", 64'(bus.o_ready), 64'd0);
    rstN = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_ready && lat < 8);
    checkOutput("reexecReady", 64'(lat), 64'd1);
    bus.i_request = 1'b0;
    @(negedge clk);
    readCheck("reexecPrescale", A_PRESCALE, 32'd33);

    // Lo-then-hi read across a carry: shadowed or live upper half.
    writeReg(A_MTIME_HI, 32'd0);
    writeReg(A_MTIME_LO, 32'hFFFF_FFFE);
    writeReg(A_PRESCALE, 32'd0);
    writeReg(A_CTRL, 32'd1);
    readCheck("snapLo", A_MTIME_LO, 32'hFFFF_FFFF);
    readCheck("snapHi", A_MTIME_HI, SNAP_HI_EXPECTED);
    writeReg(A_CTRL, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
Memory-mapped 64-bit machine timer that sits on the CPU request/ready bus as a responder, in the 0x5000_00xx peripheral window next to LED/UART/I2C/SD.
The CPU's address decoder gates i_request with the block's select and presents a block-relative byte offset.
The block runs a prescaled 64-bit up-counter (mtime) and a 64-bit compare register (mtimecmp).
It raises a level interrupt when mtime >= mtimecmp, which gives software a tick source and delay base.

Parameters:
PRESCALE, 50, reset value of the prescale register in clock cycles per mtime tick (1 MHz at 50 MHz clock).

Ports:
i_clock      input   1   system clock; all logic on rising edge
i_reset_n    input   1   synchronous, active-low reset
i_request    input   1   bus request; held high by initiator until o_ready seen
i_rw         input   1   1 = write, 0 = read
i_address    input   32  byte offset within block; only [4:2] decoded
i_wdata      input   32  write data
o_rdata      output  32  read data, registered
o_ready      output  1   access complete, registered
o_interrupt  output  1   timer interrupt, level, registered

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO (rw)
  - 0x04 MTIME_HI (rw)
  - 0x08 MTIMECMP_LO (rw)
  - 0x0C MTIMECMP_HI (rw)
  - 0x10 CTRL (rw): bit0 enable, bit1 irq_en, bit2 pending (read-only = mtime>=mtimecmp), other bits read 0
  - 0x14 PRESCALE (rw, 32 bit)
  - 0x18/0x1C: read 0, writes ignored
  - i_address[1:0] and bits above [4] ignored.
- Handshake FSM, two states:
  - IDLE: on i_request=1, the access executes at that edge. A write updates the register; a read loads o_rdata. Then o_ready<=1 and the FSM goes to ACK.
  - ACK: o_ready stays 1 while i_request=1. On i_request=0, o_ready<=0 next edge and the FSM returns to IDLE.
  - Latency: o_ready high on the cycle after request is first sampled.
  - Exactly one access per request assertion; i_rw/i_address changes during ACK are ignored.
- o_rdata holds its last read value across writes and idle cycles.
- Prescaler:
  - While CTRL.enable=1, the prescale counter counts 0..P-1. At P-1 it wraps to 0 and mtime increments by 1.
  - P = PRESCALE register; a value of 0 behaves as 1 (tick every cycle).
  - Writing PRESCALE clears the prescale counter.
  - CTRL.enable=0 freezes both counters at their current values.
- mtime wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
- A 32-bit write to either half of mtime in the same cycle as a tick: the write wins, the other half keeps its pre-tick value, and that tick is dropped.
- o_interrupt <= CTRL.irq_en && (mtime >= mtimecmp), unsigned 64-bit compare, one-cycle registered latency. It clears via a mtimecmp write or irq_en=0.
- Reset (i_reset_n=0 at an edge): mtime=0, mtimecmp=all ones, CTRL=0, PRESCALE=PRESCALE param, prescale counter=0, FSM=IDLE, o_ready=0, o_rdata=0, o_interrupt=0.
- Reset mid-access: o_ready drops and the FSM goes to IDLE. If i_request is still high after reset releases, the access re-executes as new.

Optional Feature:
TIMER_SNAPSHOT_EN
- Defined: a read of MTIME_LO also captures mtime[63:32] into a shadow register, and a read of MTIME_HI returns the shadow. This gives a coherent lo-then-hi 64-bit read. The shadow resets to 0.
- Undefined: MTIME_HI returns live mtime[63:32]; no shadow register exists.

Decomposition:
- Package bus_timer_pkg:
  - register offset constants
  - CTRL bit indices
  - FSM state encoding (IDLE, ACK)
  - mtimecmp reset constant
- Sub-module bus_timer_prescaler: enable, period, clear in; single-cycle tick out. All other logic stays in bus_timer.

Test Plan:
- Reset, then read all six offsets -> 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 50. o_ready rises 1 cycle after request and falls 1 cycle after request drops.
- PRESCALE=4, CTRL=1, wait 40 cycles -> MTIME_LO = 10 (±1 for access timing). PRESCALE=0 -> mtime increments every cycle.
- MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3, PRESCALE=1 -> o_interrupt=1 once mtime reaches 20, one cycle later. Writing MTIMECMP_LO=1000 -> o_interrupt=0; CTRL.pending mirrors the compare.
- Write MTIME_LO=0xFFFFFFFF with MTIME_HI=0, enable, one tick -> MTIME_HI=1, MTIME_LO=0. From all ones -> wraps to 0.
- Hold i_request high 10 cycles on a write of MTIME_LO=5 with enable=0 -> exactly one write, o_ready high cycles 2-10. Pulse i_reset_n low during ACK -> o_ready=0 and all registers at reset values.
- With TIMER_SNAPSHOT_EN defined: mtime=0x0000_0000_FFFF_FFFF, read LO, tick, read HI -> HI=0. Without the macro -> HI=1.
